particle_store_arb: RTL

- Controller/arbiter in front of the single-port particle record store that holds eta, phi, et and e fields.
- Shares the store between one event loader (write side) and NREQ downstream readers, such as cluster finders.
- Issues at most one store access per cycle, tracks fill level and event boundaries, and routes returned records back to the granted reader.

---
 rtl/pstore_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/particle_store_arb.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pstore_pkg.sv
// Shared constants and types for the particle record store and its arbiter.
// Store geometry lives here so the controller and any store model agree on it.
package pstore_pkg;

    localparam int AW    = 10;
    localparam int DW    = 10;
    localparam int DEPTH = 2 ** AW;

    typedef struct packed {
        logic [DW-1:0] eta;
        logic [DW-1:0] phi;
        logic [DW-1:0] et;
        logic [DW-1:0] e;
    } rec_t;

    // Store write-enable encoding.
    typedef enum logic {
        GET = 1'b0,
        PUT = 1'b1
    } st_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// NREQ-wide round-robin arbiter: grants the first request at or after ptr_i,
// wrapping modulo NREQ. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o
);

    logic found;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        // Outer loop walks the rotated search order; inner loop maps it to a fixed bit.
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req_i[j] && (j == (int'(ptr_i) + i) % NREQ)) begin
                    found    = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/particle_store_arb.sv
// Arbiter in front of the single-port particle record store: one loader, NREQ readers,
// one access per cycle. Define PSTORE_STARVE_GUARD_EN to bound write bursts against pending reads.
module particle_store_arb
    import pstore_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int MAX_WR_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 evt_start,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DW-1:0]        wr_eta,
    input  logic [DW-1:0]        wr_phi,
    input  logic [DW-1:0]        wr_et,
    input  logic [DW-1:0]        wr_e,
    input  logic [NREQ-1:0]      rd_req,
    input  logic [NREQ*AW-1:0]   rd_addr,
    output logic [NREQ-1:0]      rd_gnt,
    output logic [NREQ-1:0]      rd_valid,
    output logic                 rd_oob,
    output logic [DW-1:0]        rd_eta,
    output logic [DW-1:0]        rd_phi,
    output logic [DW-1:0]        rd_et,
    output logic [DW-1:0]        rd_e,
    output logic                 st_we,
    output logic [AW-1:0]        st_addr,
    output logic [DW-1:0]        st_eta,
    output logic [DW-1:0]        st_phi,
    output logic [DW-1:0]        st_et,
    output logic [DW-1:0]        st_e,
    input  logic [DW-1:0]        st_eta_q,
    input  logic [DW-1:0]        st_phi_q,
    input  logic [DW-1:0]        st_et_q,
    input  logic [DW-1:0]        st_e_q,
    output logic [AW:0]          count,
    output logic                 full
);

    localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [AW:0]     count_q, count_d;
    logic            full_q, full_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] rd_valid_q, rd_valid_d;
    logic            rd_oob_q, rd_oob_d;
    rec_t            hold_q;

    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic            wr_win, rd_win, guard_block;
    logic [AW-1:0]   sel_addr;
    st_op_e          st_op;
    rec_t            wr_rec, ret_rec, st_rec, rd_rec;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req_i (rd_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // Reset gates the combinational grants too, so every output reads 0 while rst is low.
    assign wr_win   = rst && !evt_start && wr_valid && !full_q && !guard_block;
    assign rd_win   = rst && !evt_start && !wr_win && (|rd_req);
    assign wr_ready = wr_win;
    assign rd_gnt   = rd_win ? arb_gnt : '0;

`ifdef PSTORE_STARVE_GUARD_EN
    localparam int BW = $clog2(MAX_WR_BURST + 1);

    logic [BW-1:0] burst_q, burst_d;

    // A blocked cycle always clears the counter so writes resume even if the reader left.
    assign guard_block = (burst_q >= BW'(MAX_WR_BURST));

    always_comb begin
        burst_d = burst_q;
        if (evt_start || rd_win || guard_block) begin
            burst_d = '0;
        end else if (wr_win && (|rd_req)) begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign guard_block = 1'b0;
`endif

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (arb_gnt[k]) begin
                sel_addr = rd_addr[k*AW +: AW];
            end
        end
    end

    assign wr_rec  = '{eta: wr_eta, phi: wr_phi, et: wr_et, e: wr_e};
    assign ret_rec = '{eta: st_eta_q, phi: st_phi_q, et: st_et_q, e: st_e_q};

    always_comb begin
        st_op   = GET;
        st_addr = '0;
        st_rec  = '0;
        if (wr_win) begin
            st_op   = PUT;
            st_addr = count_q[AW-1:0];
            st_rec  = wr_rec;
        end else if (rd_win) begin
            st_addr = sel_addr;
        end
    end

    assign st_we  = (st_op == PUT);
    assign st_eta = st_rec.eta;
    assign st_phi = st_rec.phi;
    assign st_et  = st_rec.et;
    assign st_e   = st_rec.e;

    always_comb begin
        count_d = count_q;
        if (evt_start) begin
            count_d = '0;
        end else if (wr_win && (count_q != DEPTH_C)) begin
            count_d = count_q + 1'b1;
        end
        full_d = (count_d == DEPTH_C);

        rr_ptr_d = rr_ptr_q;
        if (rd_win) begin
            rr_ptr_d = (int'(arb_idx) == NREQ - 1) ? '0 : arb_idx + 1'b1;
        end

        // Out-of-bounds is judged against the fill level at grant time.
        rd_valid_d = rd_gnt;
        rd_oob_d   = rd_win && ({1'b0, sel_addr} >= count_q);
    end

    // Return bus follows the store while valid and otherwise holds the last record.
    assign rd_rec = (|rd_valid_q) ? ret_rec : hold_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            full_q     <= 1'b0;
            rr_ptr_q   <= '0;
            rd_valid_q <= '0;
            rd_oob_q   <= 1'b0;
            hold_q     <= '0;
        end else begin
            count_q    <= count_d;
            full_q     <= full_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_oob_q   <= rd_oob_d;
            hold_q     <= rd_rec;
        end
    end

    assign count    = count_q;
    assign full     = full_q;
    assign rd_valid = rd_valid_q;
    assign rd_oob   = rd_oob_q;
    assign rd_eta   = rd_rec.eta;
    assign rd_phi   = rd_rec.phi;
    assign rd_et    = rd_rec.et;
    assign rd_e     = rd_rec.e;

endmodule
